// File: rtl/mul_adr_pkg.sv
// Shared widths, FSM encoding and counter sizing for the mul_adr accumulation stage.
package mul_adr_pkg;

    localparam int P_W     = 16;
    localparam int S_W     = 9;
    localparam int ACC_W   = 32;
    localparam int ACC_LEN = 16;

    // Beat counter only needs to reach ACC_LEN-1 before wrapping.
    function automatic int cnt_width(input int len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    localparam int CNT_W = cnt_width(ACC_LEN);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned W-bit add that clamps to all-ones on carry-out and flags the clamp.
// Purely combinational: zero latency, no flow control.
module sat_add #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sat = raw[W];
    assign sum = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/mul_adr_acc.sv
// Saturating frame accumulator for product/sum beats; totals valid 1 cycle after the last beat.
// Backpressure: in_ready drops while a frame total waits in HOLD for out_ready.
module mul_adr_acc
    import mul_adr_pkg::*;
#(
    parameter int P_W     = mul_adr_pkg::P_W,
    parameter int S_W     = mul_adr_pkg::S_W,
    parameter int ACC_W   = mul_adr_pkg::ACC_W,
    parameter int ACC_LEN = mul_adr_pkg::ACC_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [P_W-1:0]   p_in,
    input  logic [S_W-1:0]   s_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] p_acc,
    output logic [ACC_W-1:0] s_acc,
    output logic             ovf
);

    localparam int                CNT_W = cnt_width(ACC_LEN);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(ACC_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   p_acc_d, s_acc_d;
    logic               ovf_d, out_valid_d;

    logic [ACC_W-1:0]   p_ext, s_ext, p_sum, s_sum;
    logic               p_sat, s_sat, accept;

    assign p_ext    = {{(ACC_W-P_W){1'b0}}, p_in};
    assign s_ext    = {{(ACC_W-S_W){1'b0}}, s_in};
    assign in_ready = (state_q == ST_ACC);
    assign accept   = in_valid & in_ready;

    sat_add #(.W(ACC_W)) u_p_add (
        .a   (p_acc),
        .b   (p_ext),
        .sum (p_sum),
        .sat (p_sat)
    );

    sat_add #(.W(ACC_W)) u_s_add (
        .a   (s_acc),
        .b   (s_ext),
        .sum (s_sum),
        .sat (s_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            p_acc     <= '0;
            s_acc     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_acc     <= p_acc_d;
            s_acc     <= s_acc_d;
            ovf       <= ovf_d;
            out_valid <= out_valid_d;
        end
    end

    // clear outranks both the input accept and the output handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_acc_d     = p_acc;
        s_acc_d     = s_acc;
        ovf_d       = ovf;
        out_valid_d = out_valid;

        if (clear) begin
            state_d     = ST_ACC;
            cnt_d       = '0;
            p_acc_d     = '0;
            s_acc_d     = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        p_acc_d = p_sum;
                        s_acc_d = s_sum;
                        ovf_d   = ovf | p_sat | s_sat;
                        if (cnt_q == LAST) begin
                            cnt_d       = '0;
                            state_d     = ST_HOLD;
                            out_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid & out_ready) begin
                        state_d     = ST_ACC;
                        p_acc_d     = '0;
                        s_acc_d     = '0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_adr_acc.sv
// Bench for mul_adr_acc: a 4-beat/32-bit instance and a 17-beat/20-bit saturating instance.
module tb_mul_adr_acc;

    localparam int LEN_A = 4;
    localparam int W_A   = 32;
    localparam int LEN_B = 17;
    localparam int W_B   = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            clear_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, ovf_a;
    logic [15:0]     p_in_a;
    logic [8:0]      s_in_a;
    logic [W_A-1:0]  p_acc_a, s_acc_a;

    logic            clear_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, ovf_b;
    logic [15:0]     p_in_b;
    logic [8:0]      s_in_b;
    logic [W_B-1:0]  p_acc_b, s_acc_b;

    int errors = 0;
    int checks = 0;

    mul_adr_acc #(.P_W(16), .S_W(9), .ACC_W(W_A), .ACC_LEN(LEN_A)) dut_a (
        .clk(clk), .rst(rst), .clear(clear_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .p_in(p_in_a), .s_in(s_in_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .p_acc(p_acc_a), .s_acc(s_acc_a), .ovf(ovf_a)
    );

    mul_adr_acc #(.P_W(16), .S_W(9), .ACC_W(W_B), .ACC_LEN(LEN_B)) dut_b (
        .clk(clk), .rst(rst), .clear(clear_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .p_in(p_in_b), .s_in(s_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .p_acc(p_acc_b), .s_acc(s_acc_b), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] get_p(input bit sel);
        return sel ? 64'(p_acc_b) : 64'(p_acc_a);
    endfunction
    function automatic logic [63:0] get_s(input bit sel);
        return sel ? 64'(s_acc_b) : 64'(s_acc_a);
    endfunction
    function automatic logic get_ovf(input bit sel);
        return sel ? ovf_b : ovf_a;
    endfunction
    function automatic logic get_ovld(input bit sel);
        return sel ? out_valid_b : out_valid_a;
    endfunction
    function automatic logic get_irdy(input bit sel);
        return sel ? in_ready_b : in_ready_a;
    endfunction

    // Present one beat and hold it until the DUT takes it (bounded wait).
    task automatic send_beat(input bit sel, input logic [15:0] p, input logic [8:0] s);
        int n = 0;
        if (sel) begin in_valid_b = 1'b1; p_in_b = p; s_in_b = s; end
        else     begin in_valid_a = 1'b1; p_in_a = p; s_in_a = s; end
        while (!get_irdy(sel) && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 64'(get_irdy(sel)), 64'd1);
        step();
        if (sel) in_valid_b = 1'b0;
        else     in_valid_a = 1'b0;
    endtask

    // Reference: saturated total = min(true total, max); ovf iff the true total exceeds max.
    task automatic expect_frame(input bit sel, input string tag, input longint tp, input longint ts,
                                input int w, input int stall);
        longint      mx;
        logic [63:0] ep, es;
        logic        eovf;
        mx   = (longint'(1) << w) - 1;
        ep   = (tp > mx) ? mx : tp;
        es   = (ts > mx) ? mx : ts;
        eovf = (tp > mx) || (ts > mx);
        if (sel) out_ready_b = (stall == 0);
        else     out_ready_a = (stall == 0);
        chk({tag, "_ovld"}, 64'(get_ovld(sel)), 64'd1);
        chk({tag, "_irdy"}, 64'(get_irdy(sel)), 64'd0);
        chk({tag, "_p"},    get_p(sel), ep);
        chk({tag, "_s"},    get_s(sel), es);
        chk({tag, "_ovf"},  64'(get_ovf(sel)), 64'(eovf));
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_stall_ovld"}, 64'(get_ovld(sel)), 64'd1);
            chk({tag, "_stall_p"},    get_p(sel), ep);
            chk({tag, "_stall_irdy"}, 64'(get_irdy(sel)), 64'd0);
        end
        if (sel) out_ready_b = 1'b1;
        else     out_ready_a = 1'b1;
        step();
        if (sel) out_ready_b = 1'b0;
        else     out_ready_a = 1'b0;
        chk({tag, "_done_ovld"}, 64'(get_ovld(sel)), 64'd0);
        chk({tag, "_done_irdy"}, 64'(get_irdy(sel)), 64'd1);
        chk({tag, "_done_p"},    get_p(sel), 64'd0);
        chk({tag, "_done_s"},    get_s(sel), 64'd0);
        chk({tag, "_done_ovf"},  64'(get_ovf(sel)), 64'd0);
    endtask

    task automatic run_frame(input bit sel, input string tag, input int maxgap, input bit big,
                             input int stall);
        longint      tp = 0, ts = 0;
        logic [15:0] p;
        logic [8:0]  s;
        int          len;
        len = sel ? LEN_B : LEN_A;
        for (int i = 0; i < len; i++) begin
            p = big ? 16'($urandom_range(40000, 65535)) : 16'($urandom_range(0, 65535));
            s = 9'($urandom_range(0, 511));
            tp += p;
            ts += s;
            repeat ($urandom_range(0, maxgap)) step();
            send_beat(sel, p, s);
        end
        expect_frame(sel, tag, tp, ts, sel ? W_B : W_A, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_a = 0; in_valid_a = 0; out_ready_a = 0; p_in_a = 0; s_in_a = 0;
        clear_b = 0; in_valid_b = 0; out_ready_b = 0; p_in_b = 0; s_in_b = 0;
        #2;
        chk("rst_ovld", 64'(out_valid_a), 64'd0);
        chk("rst_p",    64'(p_acc_a), 64'd0);
        chk("rst_s",    64'(s_acc_a), 64'd0);
        chk("rst_ovf",  64'(ovf_a), 64'd0);
        step();
        step();
        rst = 1'b0;
        chk("rst_irdy_a", 64'(in_ready_a), 64'd1);
        chk("rst_irdy_b", 64'(in_ready_b), 64'd1);

        // Basic back-to-back frame
        out_ready_a = 1'b1;
        send_beat(0, 16'd100, 9'd1);
        send_beat(0, 16'd200, 9'd2);
        send_beat(0, 16'd300, 9'd3);
        send_beat(0, 16'd400, 9'd4);
        expect_frame(0, "basic", 1000, 10, W_A, 0);

        // Gapped input, 5-cycle stall
        for (int i = 0; i < 4; i++) begin
            step();
            send_beat(0, 16'd65025, 9'd510);
        end
        expect_frame(0, "gapped", 260100, 2040, W_A, 5);

        // Saturation, then a small frame, then an exact-max frame
        for (int i = 0; i < LEN_B; i++) send_beat(1, 16'd65025, 9'd0);
        expect_frame(1, "sat", 64'd65025 * LEN_B, 0, W_B, 2);
        for (int i = 0; i < LEN_B; i++) send_beat(1, 16'd1, 9'd1);
        expect_frame(1, "sat_small", LEN_B, LEN_B, W_B, 0);
        for (int i = 0; i < LEN_B - 1; i++) send_beat(1, 16'd65535, 9'd511);
        send_beat(1, 16'd15, 9'd511);
        expect_frame(1, "sat_exact", 1048575, 511 * LEN_B, W_B, 1);

        // Clear mid-frame with a coincident beat
        send_beat(0, 16'd10, 9'd0);
        send_beat(0, 16'd10, 9'd0);
        in_valid_a = 1'b1; p_in_a = 16'd99; s_in_a = 9'd0; clear_a = 1'b1;
        step();
        in_valid_a = 1'b0; clear_a = 1'b0;
        chk("clr_p",    64'(p_acc_a), 64'd0);
        chk("clr_irdy", 64'(in_ready_a), 64'd1);
        for (int i = 0; i < 4; i++) send_beat(0, 16'd1, 9'd0);
        expect_frame(0, "clr_frame", 4, 0, W_A, 0);

        // Asynchronous reset while holding totals
        send_beat(0, 16'd5, 9'd1);
        send_beat(0, 16'd6, 9'd1);
        send_beat(0, 16'd7, 9'd1);
        send_beat(0, 16'd8, 9'd1);
        chk("arst_pre_ovld", 64'(out_valid_a), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_ovld", 64'(out_valid_a), 64'd0);
        chk("arst_p",    64'(p_acc_a), 64'd0);
        chk("arst_s",    64'(s_acc_a), 64'd0);
        chk("arst_ovf",  64'(ovf_a), 64'd0);
        #2 rst = 1'b0;
        chk("arst_irdy", 64'(in_ready_a), 64'd1);
        step();
        send_beat(0, 16'd1, 9'd4);
        send_beat(0, 16'd2, 9'd4);
        send_beat(0, 16'd3, 9'd4);
        send_beat(0, 16'd4, 9'd4);
        expect_frame(0, "arst_frame", 10, 16, W_A, 0);

        // Clear racing the output handshake
        for (int i = 0; i < 4; i++) send_beat(0, 16'd50, 9'd2);
        chk("hclr_pre_ovld", 64'(out_valid_a), 64'd1);
        clear_a = 1'b1; out_ready_a = 1'b1;
        step();
        clear_a = 1'b0; out_ready_a = 1'b0;
        chk("hclr_ovld", 64'(out_valid_a), 64'd0);
        chk("hclr_irdy", 64'(in_ready_a), 64'd1);
        chk("hclr_p",    64'(p_acc_a), 64'd0);
        chk("hclr_ovf",  64'(ovf_a), 64'd0);
        step();
        chk("hclr_ovld2", 64'(out_valid_a), 64'd0);
        for (int i = 0; i < 4; i++) send_beat(0, 16'd7, 9'd3);
        expect_frame(0, "hclr_frame", 28, 12, W_A, 0);

        // Randomized frames
        for (int f = 0; f < 6; f++)
            run_frame(0, "rand_a", 2, 1'b0, $urandom_range(0, 3));
        for (int f = 0; f < 4; f++)
            run_frame(1, "rand_b", 1, f[0], $urandom_range(0, 2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
